// File: rtl/phys_reg_free_list.sv
// Physical-register free list: circular FIFO of rename tags, two pushes and one pop per cycle.
// Optional duplicate-release detection is enabled with `define FREE_LIST_DUP_CHECK_EN.
module phys_reg_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int TAG_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  input  logic [TAG_W-1:0] freed_tag_1,
  input  logic [TAG_W-1:0] freed_tag_2,
  output logic [TAG_W:0]   free_count,
  output logic             overflow_err
`ifdef FREE_LIST_DUP_CHECK_EN
  ,
  output logic             dup_err
`endif
);

  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = TAG_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Explicit wrap so DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] tail_plus1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] space;
  logic             overflow_q, overflow_d;
  logic             pop;
  logic             want1, want2;
  logic             acc1, acc2;

`ifdef FREE_LIST_DUP_CHECK_EN
  localparam logic [NUM_PHYS-1:0] IN_LIST_INIT = {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};
  logic [NUM_PHYS-1:0] in_list_q, in_list_d;
  logic                dup_q, dup_d;
  logic                dup1, dup2;
`endif

  always_comb begin
    pop   = alloc_req && (count_q != '0);
    space = DEPTH_CNT - count_q + CNT_W'(pop);
    want1 = (freed_tag_1 != '0);
    want2 = (freed_tag_2 != '0);
`ifdef FREE_LIST_DUP_CHECK_EN
    dup1  = want1 && in_list_q[freed_tag_1];
    dup2  = want2 && (in_list_q[freed_tag_2] || (freed_tag_2 == freed_tag_1));
    want1 = want1 && !dup1;
    want2 = want2 && !dup2;
    dup_d = dup_q | dup1 | dup2;
`endif
    // Capacity counts the slot freed by this cycle's pop; freed_tag_1 wins a single free slot.
    acc1 = want1 && (space != '0);
    acc2 = want2 && (acc1 ? (space >= CNT_W'(2)) : (space != '0));

    tail_plus1 = ptr_inc(tail_q);
    mem_d = mem_q;
    if (acc1) mem_d[tail_q] = freed_tag_1;
    if (acc2) mem_d[acc1 ? tail_plus1 : tail_q] = freed_tag_2;

    if (acc1 && acc2)      tail_d = ptr_inc(tail_plus1);
    else if (acc1 || acc2) tail_d = tail_plus1;
    else                   tail_d = tail_q;

    head_d     = pop ? ptr_inc(head_q) : head_q;
    count_d    = count_q + CNT_W'(acc1) + CNT_W'(acc2) - CNT_W'(pop);
    overflow_d = overflow_q | (want1 & ~acc1) | (want2 & ~acc2);

`ifdef FREE_LIST_DUP_CHECK_EN
    in_list_d = in_list_q;
    if (pop)  in_list_d[mem_q[head_q]] = 1'b0;
    if (acc1) in_list_d[freed_tag_1]   = 1'b1;
    if (acc2) in_list_d[freed_tag_2]   = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(NUM_ARCH + i);
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= DEPTH_CNT;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_list_q <= IN_LIST_INIT;
      dup_q     <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      dup_q     <= dup_d;
    end
  end

  assign dup_err = dup_q;
`endif

  // No bypass: the head reflects registered state only.
  assign alloc_valid  = (count_q != '0);
  assign alloc_tag    = (count_q != '0) ? mem_q[head_q] : '0;
  assign free_count   = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: queue-based reference model feeding an expectation scoreboard.
// Define FREE_LIST_DUP_CHECK_EN to also exercise duplicate-release detection.
module tb_phys_reg_free_list;

  localparam int NUM_ARCH = 32;
  localparam int DEPTH    = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [5:0] alloc_tag;
  logic       alloc_valid;
  logic [5:0] freed_tag_1;
  logic [5:0] freed_tag_2;
  logic [6:0] free_count;
  logic       overflow_err;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic       dup_err;
`endif

  phys_reg_free_list #(.NUM_PHYS(64), .NUM_ARCH(NUM_ARCH), .TAG_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_tag    (alloc_tag),
    .alloc_valid  (alloc_valid),
    .freed_tag_1  (freed_tag_1),
    .freed_tag_2  (freed_tag_2),
    .free_count   (free_count),
    .overflow_err (overflow_err)
`ifdef FREE_LIST_DUP_CHECK_EN
    ,
    .dup_err      (dup_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int valid;
    int count;
    int ovf;
    int dup;
  } exp_t;

  exp_t expQ[$];
  int   modelList[$];
  int   modelOvf;
  int   modelDup;
  int   numCompared;
  int   numMismatched;

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, observed, expected);
    end
  endtask

  function automatic bit inModel(input int t);
    foreach (modelList[i]) if (modelList[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t modelExpect();
    exp_t e;
    e.count = modelList.size();
    e.valid = (modelList.size() != 0) ? 1 : 0;
    e.tag   = (modelList.size() != 0) ? modelList[0] : 0;
    e.ovf   = modelOvf;
    e.dup   = modelDup;
    return e;
  endfunction

  task automatic modelReset();
    modelList.delete();
    for (int i = 0; i < DEPTH; i++) modelList.push_back(NUM_ARCH + i);
    modelOvf = 0;
    modelDup = 0;
  endtask

  task automatic modelStep(input bit req, input int t1, input int t2);
    bit pop;
    int space;
    bit keep1;
    bit keep2;
    pop   = req && (modelList.size() > 0);
    space = DEPTH - modelList.size() + (pop ? 1 : 0);
    keep1 = (t1 != 0);
    keep2 = (t2 != 0);
`ifdef FREE_LIST_DUP_CHECK_EN
    if (keep1 && inModel(t1)) begin keep1 = 0; modelDup = 1; end
    if (keep2 && (inModel(t2) || t2 == t1)) begin keep2 = 0; modelDup = 1; end
`endif
    if (pop) void'(modelList.pop_front());
    if (keep1) begin
      if (space > 0) begin modelList.push_back(t1); space--; end
      else modelOvf = 1;
    end
    if (keep2) begin
      if (space > 0) begin modelList.push_back(t2); space--; end
      else modelOvf = 1;
    end
  endtask

  task automatic checkState(input string phase);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({phase, ".scoreboard_empty"}, 1, 0);
      return;
    end
    e = expQ.pop_front();
    checkOutput({phase, ".alloc_valid"},  alloc_valid,  e.valid);
    checkOutput({phase, ".alloc_tag"},    alloc_tag,    e.tag);
    checkOutput({phase, ".free_count"},   free_count,   e.count);
    checkOutput({phase, ".overflow_err"}, overflow_err, e.ovf);
`ifdef FREE_LIST_DUP_CHECK_EN
    checkOutput({phase, ".dup_err"},      dup_err,      e.dup);
`endif
  endtask

  // Drive one cycle of stimulus, check the combinational head before the edge and the state after it.
  task automatic applyStimulus(input bit req, input int t1, input int t2, input string name);
    @(negedge clk);
    alloc_req   = req;
    freed_tag_1 = 6'(t1);
    freed_tag_2 = 6'(t2);
    #1;
    expQ.push_back(modelExpect());
    checkState({name, "/pre"});
    modelStep(req, t1, t2);
    expQ.push_back(modelExpect());
    @(posedge clk);
    #1;
    checkState({name, "/post"});
    alloc_req   = 1'b0;
    freed_tag_1 = '0;
    freed_tag_2 = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("reset.alloc_tag",    alloc_tag,    32);
    checkOutput("reset.alloc_valid",  alloc_valid,  1);
    checkOutput("reset.free_count",   free_count,   32);
    checkOutput("reset.overflow_err", overflow_err, 0);
  endtask

  initial begin
    int t1;
    int t2;
    numCompared   = 0;
    numMismatched = 0;
    reset       = 1'b1;
    alloc_req   = 1'b0;
    freed_tag_1 = '0;
    freed_tag_2 = '0;
    repeat (2) @(negedge clk);
    doReset();

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 0, "pop3");
    checkOutput("pop3.free_count", free_count, 29);
    checkOutput("pop3.alloc_tag",  alloc_tag,  35);

    for (int i = 0; i < 29; i++) applyStimulus(1'b1, 0, 0, "drain");
    checkOutput("empty.alloc_valid", alloc_valid, 0);
    checkOutput("empty.alloc_tag",   alloc_tag,   0);
    applyStimulus(1'b1, 0, 0, "pop_empty");
    checkOutput("pop_empty.free_count",   free_count,   0);
    checkOutput("pop_empty.overflow_err", overflow_err, 0);

    applyStimulus(1'b0, 5, 7, "push57");
    checkOutput("push57.alloc_tag",  alloc_tag,  5);
    checkOutput("push57.free_count", free_count, 2);
    applyStimulus(1'b1, 0, 0, "pop5");
    checkOutput("pop5.alloc_tag", alloc_tag, 7);

    for (int k = 0; k < 15; k++) applyStimulus(1'b0, 8 + 2 * k, 9 + 2 * k, "fill");
    checkOutput("fill.free_count", free_count, 31);
    applyStimulus(1'b0, 3, 4, "ovf");
    checkOutput("ovf.free_count",   free_count,   32);
    checkOutput("ovf.overflow_err", overflow_err, 1);

    doReset();
    applyStimulus(1'b1, 0, 0, "to31");
    applyStimulus(1'b1, 3, 4, "pop_push");
    checkOutput("pop_push.free_count",   free_count,   32);
    checkOutput("pop_push.overflow_err", overflow_err, 0);

    for (int i = 0; i < 40; i++) begin
      t1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
      t2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
      applyStimulus(1'($urandom_range(0, 1)), t1, t2, "random");
    end

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0, 0, "midpop");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset.alloc_tag",    alloc_tag,    32);
    checkOutput("async_reset.free_count",   free_count,   32);
    checkOutput("async_reset.alloc_valid",  alloc_valid,  1);
    checkOutput("async_reset.overflow_err", overflow_err, 0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

`ifdef FREE_LIST_DUP_CHECK_EN
    applyStimulus(1'b1, 0, 0, "dup_prep");
    applyStimulus(1'b0, 40, 0, "dup40");
    checkOutput("dup40.dup_err",    dup_err,    1);
    checkOutput("dup40.free_count", free_count, 31);
    applyStimulus(1'b0, 9, 9, "dup_pair");
    checkOutput("dup_pair.free_count", free_count, 32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Physical-register free list for the rename stage. It receives the tags the reorder buffer releases at commit on its `freed_tag_1`/`freed_tag_2` interface, and returns them later as fresh destination tags for renamed instructions. It is a circular FIFO with two pushes and one pop per cycle. At reset it holds every physical tag not mapped to an architectural register.

Parameters:
- NUM_PHYS, 64, number of physical registers.
- NUM_ARCH, 32, number of architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
- TAG_W, 6, tag width; must satisfy 2^TAG_W >= NUM_PHYS.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- alloc_req  input  1  rename requests one tag this cycle
- alloc_tag  output  TAG_W  tag at the head of the list; valid when alloc_valid=1
- alloc_valid  output  1  list not empty
- freed_tag_1  input  TAG_W  first tag released by the ROB; 0 = no release
- freed_tag_2  input  TAG_W  second tag released by the ROB; 0 = no release
- free_count  output  TAG_W+1  number of tags currently in the list
- overflow_err  output  1  sticky error: a push was attempted with the list full

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on `reset`. While reset is high, and immediately on its assertion, the block restores its reset state.
- Storage:
  - DEPTH = NUM_PHYS - NUM_ARCH entries (32 by default).
  - Head and tail pointers wrap from DEPTH-1 to 0 explicitly; DEPTH need not be a power of two.
- Reset state:
  - entry i = NUM_ARCH + i.
  - head = 0, tail = 0, count = DEPTH.
  - overflow_err = 0.
  - alloc_tag = NUM_ARCH, alloc_valid = 1.
  - A reset mid-operation discards all in-flight state and restores this state.
- alloc_tag and alloc_valid are combinational from head and count; there is no registered output latency.
  - alloc_valid = (count != 0).
  - alloc_tag = entry[head] when count != 0, otherwise 0.
- Pop: when alloc_req=1 and count != 0, head advances on the clock edge. alloc_req with count=0 is ignored with no state change and no error.
- Pushes:
  - A freed tag equal to 0 is never pushed; tag 0 (x0) is never freed.
  - Non-zero tags are written in order freed_tag_1 then freed_tag_2, into consecutive slots starting at tail.
  - If only freed_tag_2 is non-zero, it goes to tail.
- Push capacity is evaluated after the same-cycle pop:
  - space = DEPTH - count + pop.
  - Pushes beyond space are dropped, and overflow_err is set and held until reset.
  - freed_tag_1 takes priority over freed_tag_2.
- No bypass: a tag pushed while the list is empty is first visible on alloc_tag on the next cycle.
- Count update: count_next = count + pushes_accepted - pop. It is never negative and never exceeds DEPTH.
- Simultaneous pop and push with count=1: the head tag is popped and the new tags are appended. On the next cycle alloc_tag shows the first new tag.
- Wrap: pointer increments of +1 and +2 wrap modulo DEPTH, e.g. tail=31 with two pushes gives tail=1.

Optional Feature:
- Macro name: FREE_LIST_DUP_CHECK_EN.
- Defined:
  - The block keeps an NUM_PHYS-bit in_list bitmap; at reset, bits NUM_ARCH..NUM_PHYS-1 are 1.
  - A freed tag whose bit is already 1 is dropped; likewise freed_tag_2 is dropped when it equals a non-zero freed_tag_1.
  - Either drop sets the extra output port `dup_err` (1 bit, sticky, reset 0).
  - Bits are cleared on pop and set on accepted push.
- Undefined:
  - No bitmap and no `dup_err` port.
  - Duplicate tags are pushed like any other tag.

Test Plan:
- Release reset -> alloc_tag=32, alloc_valid=1, free_count=32, overflow_err=0.
- alloc_req=1 for 3 cycles -> alloc_tag reads 32, 33, 34 on successive cycles; then free_count=29 and alloc_tag=35.
- Pop all 32 tags -> alloc_valid=0, alloc_tag=0. A further alloc_req leaves free_count=0 with no error.
- From empty, freed_tag_1=5 and freed_tag_2=7 in the same cycle -> alloc_valid=0 that cycle; next cycle alloc_tag=5, free_count=2; after one pop, alloc_tag=7.
- At count=31: freed_tag_1=3 and freed_tag_2=4 with alloc_req=0 -> 3 accepted, 4 dropped, overflow_err=1. Repeat with alloc_req=1 -> both accepted, no error.
- Assert reset mid-stream (head=10, tail=20) -> alloc_tag=32 and free_count=32 immediately, without waiting for a clock edge. With FREE_LIST_DUP_CHECK_EN defined, freeing tag 40 while it is still in the list -> dup_err=1 and free_count unchanged.
